// File: rtl/aes_decrypt_iter.sv
// rtl/aes_decrypt_iter.sv - iterative AES-128 decryption core with on-the-fly inverse key schedule
// Round key 10 is built by forward expansion, then keys are walked back one per inverse round.

module gf_inv (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = p ^ t;
            t = xt(t);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
    always_comb begin
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gmul(p, p);
            acc = gmul(acc, p);
        end
        y = acc;
    end
endmodule

module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] inv;

    gf_inv u_inv (.a(a), .y(inv));

    assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] t;

    assign t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;

    gf_inv u_inv (.a(t), .y(y));
endmodule

module aes_decrypt_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] ciphertext,
    output logic         busy,
    output logic         done,
    output logic [127:0] plaintext
);
    typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL} state_t;

    state_t       state, state_n;
    logic [127:0] st, rk;
    logic [3:0]   cnt;

    logic [127:0] shifted, subbed, ark, imc;
    logic [31:0]  kw, rot, subw, rcw;
    logic [127:0] fwd_key, inv_key;
    logic [3:0]   rc_idx;

    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] inv_shift(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c - r + 4) % 4) + r) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    assign shifted = inv_shift(st);

    for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
        inv_sbox u_isb (.a(shifted[127-8*i -: 8]), .y(subbed[127-8*i -: 8]));
    end

    assign ark = subbed ^ rk;
    assign imc = {inv_mix_col(ark[127:96]), inv_mix_col(ark[95:64]),
                  inv_mix_col(ark[63:32]),  inv_mix_col(ark[31:0])};

    // One S-box set serves both directions: forward uses word 3, inverse uses the recovered w3
    assign kw     = (state == KEYEXP) ? rk[31:0] : (rk[31:0] ^ rk[63:32]);
    assign rot    = {kw[23:0], kw[31:24]};
    assign rc_idx = (state == INIT) ? 4'd10 : cnt;
    assign rcw    = {rcon(rc_idx), 24'h0};

    for (genvar j = 0; j < 4; j++) begin : g_key_sbox
        sbox u_sb (.a(rot[31-8*j -: 8]), .y(subw[31-8*j -: 8]));
    end

    always_comb begin
        logic [31:0] w0, w1, w2, w3;
        w0      = rk[127:96] ^ subw ^ rcw;
        w1      = rk[95:64] ^ w0;
        w2      = rk[63:32] ^ w1;
        w3      = rk[31:0] ^ w2;
        fwd_key = {w0, w1, w2, w3};
        inv_key = {rk[127:96] ^ subw ^ rcw, rk[95:64] ^ rk[127:96],
                   rk[63:32] ^ rk[95:64], rk[31:0] ^ rk[63:32]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = KEYEXP;
            KEYEXP:  if (cnt == 4'd10) state_n = INIT;
            INIT:    state_n = ROUND;
            ROUND:   if (cnt == 4'd1) state_n = FINAL;
            FINAL:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= '0;
            rk        <= '0;
            cnt       <= '0;
            plaintext <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == FINAL);
            case (state)
                IDLE: if (start) begin
                    st  <= ciphertext;
                    rk  <= key;
                    cnt <= 4'd1;
                end
                KEYEXP: begin
                    rk  <= fwd_key;
                    cnt <= cnt + 4'd1;
                end
                INIT: begin
                    st  <= st ^ rk;
                    rk  <= inv_key;
                    cnt <= 4'd9;
                end
                ROUND: begin
                    st  <= imc;
                    rk  <= inv_key;
                    cnt <= cnt - 4'd1;
                end
                FINAL:   plaintext <= ark;
                default: ;
            endcase
        end
    end
endmodule
